// File: rtl/cluster_cfg_responder.sv
// Purpose : AXI4 write-only responder holding the cluster boot configuration registers.
// Latency : w_ready the cycle after AW handshake; b_valid the cycle after the final W beat.
// Backpressure: one transaction in flight; aw_ready low outside ADDR, B held stable until b_ready.
//
// Ports: clk/rst_n (async active-low); AXI AW/W/B write channels; reg_q (N_REGS x 32 bits,
// register k at [32k+31:32k]); wr_mask (per-register written flags); cfg_complete (all written);
// cfg_clear (synchronous clear of wr_mask).
// Optional: define CLUSTER_CFG_ERRCNT_EN to add err_count, a saturating count of SLVERR responses.
module cluster_cfg_responder #(
  parameter int          N_REGS    = 4,
  parameter int          ID_WIDTH  = 4,
  parameter logic [31:0] BASE_ADDR = 32'h1A10_0000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  aw_valid,
  output logic                  aw_ready,
  input  logic [31:0]           aw_addr,
  input  logic [7:0]            aw_len,
  input  logic [2:0]            aw_size,
  input  logic [1:0]            aw_burst,
  input  logic [ID_WIDTH-1:0]   aw_id,
  input  logic                  w_valid,
  output logic                  w_ready,
  input  logic [31:0]           w_data,
  input  logic [3:0]            w_strb,
  input  logic                  w_last,
  output logic                  b_valid,
  input  logic                  b_ready,
  output logic [1:0]            b_resp,
  output logic [ID_WIDTH-1:0]   b_id,
  output logic [32*N_REGS-1:0]  reg_q,
  output logic [N_REGS-1:0]     wr_mask,
  output logic                  cfg_complete,
  input  logic                  cfg_clear
`ifdef CLUSTER_CFG_ERRCNT_EN
  ,
  output logic [15:0]           err_count
`endif
);

  typedef enum logic [1:0] {ADDR, DATA, RESP} state_t;

  // One past the last register byte address, in 33 bits so a window ending at 2^32 still compares.
  localparam logic [32:0] LIMIT = {1'b0, BASE_ADDR} + 33'(4 * N_REGS);

  state_t              state;
  logic [31:0]         beat_addr;
  logic                beat_wrap;   // set once the running beat address has carried past 2^32
  logic [7:0]          len_q;
  logic [7:0]          beat_cnt;
  logic [ID_WIDTH-1:0] id_q;
  logic                legal_q;
  logic                err_q;

  logic        aw_legal;
  logic        w_hs;
  logic        last_beat;
  logic        in_range;
  logic        beat_err;
  logic        do_write;
  logic [31:0] beat_index;
  logic [32:0] next_addr;

  assign aw_legal   = (aw_size == 3'b010) && (aw_burst == 2'b01);
  assign w_hs       = w_valid && w_ready;
  assign last_beat  = (beat_cnt == len_q);
  assign in_range   = !beat_wrap && (beat_addr >= BASE_ADDR) &&
                      ({1'b0, beat_addr} < LIMIT) && (beat_addr[1:0] == 2'b00);
  assign beat_index = (beat_addr - BASE_ADDR) >> 2;
  // A w_last that disagrees with the aw_len beat count is an error but never ends the burst.
  assign beat_err   = !in_range || (w_last != last_beat);
  assign do_write   = w_hs && legal_q && in_range;
  assign next_addr  = {1'b0, beat_addr} + 33'd4;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ADDR;
      aw_ready  <= 1'b1;
      w_ready   <= 1'b0;
      b_valid   <= 1'b0;
      b_resp    <= 2'b00;
      b_id      <= '0;
      beat_addr <= '0;
      beat_wrap <= 1'b0;
      len_q     <= '0;
      beat_cnt  <= '0;
      id_q      <= '0;
      legal_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      case (state)
        ADDR: begin
          if (aw_valid && aw_ready) begin
            beat_addr <= aw_addr;
            beat_wrap <= 1'b0;
            len_q     <= aw_len;
            beat_cnt  <= '0;
            id_q      <= aw_id;
            legal_q   <= aw_legal;
            err_q     <= !aw_legal;
            aw_ready  <= 1'b0;
            w_ready   <= 1'b1;
            state     <= DATA;
          end
        end
        DATA: begin
          if (w_hs) begin
            beat_addr <= next_addr[31:0];
            beat_wrap <= beat_wrap | next_addr[32];
            beat_cnt  <= beat_cnt + 8'd1;
            err_q     <= err_q | beat_err;
            if (last_beat) begin
              w_ready <= 1'b0;
              b_valid <= 1'b1;
              b_resp  <= (err_q || beat_err) ? 2'b10 : 2'b00;
              b_id    <= id_q;
              state   <= RESP;
            end
          end
        end
        RESP: begin
          if (b_ready) begin
            b_valid  <= 1'b0;
            aw_ready <= 1'b1;
            state    <= ADDR;
          end
        end
        default: begin
          state    <= ADDR;
          aw_ready <= 1'b1;
          w_ready  <= 1'b0;
          b_valid  <= 1'b0;
        end
      endcase
    end
  end

  // Register bank and written-flags; cfg_clear is applied last so it overrides a same-cycle set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_q        <= '0;
      wr_mask      <= '0;
      cfg_complete <= 1'b0;
    end else begin
      for (int k = 0; k < N_REGS; k++) begin
        if (do_write && (beat_index == 32'(k))) begin
          for (int b = 0; b < 4; b++) begin
            if (w_strb[b]) reg_q[32*k + 8*b +: 8] <= w_data[8*b +: 8];
          end
          wr_mask[k] <= 1'b1;
        end
      end
      if (cfg_clear) wr_mask <= '0;
      cfg_complete <= &wr_mask;
    end
  end

`ifdef CLUSTER_CFG_ERRCNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= '0;
    end else if (cfg_clear) begin
      err_count <= '0;
    end else if (b_valid && b_ready && (b_resp == 2'b10) && (err_count != 16'hFFFF)) begin
      err_count <= err_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cluster_cfg_responder.sv
module tb_cluster_cfg_responder;
  localparam logic [31:0] BASE = 32'h1A10_0000;

  logic         clk;
  logic         rst_n;
  logic         aw_valid, aw_ready;
  logic [31:0]  aw_addr;
  logic [7:0]   aw_len;
  logic [2:0]   aw_size;
  logic [1:0]   aw_burst;
  logic [3:0]   aw_id;
  logic         w_valid, w_ready;
  logic [31:0]  w_data;
  logic [3:0]   w_strb;
  logic         w_last;
  logic         b_valid, b_ready;
  logic [1:0]   b_resp;
  logic [3:0]   b_id;
  logic [127:0] reg_q;
  logic [3:0]   wr_mask;
  logic         cfg_complete;
  logic         cfg_clear;
`ifdef CLUSTER_CFG_ERRCNT_EN
  logic [15:0]  err_count;
`endif

  int n_pass  = 0;
  int n_total = 0;

  cluster_cfg_responder #(.N_REGS(4), .ID_WIDTH(4), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst_n(rst_n),
    .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_addr(aw_addr), .aw_len(aw_len),
    .aw_size(aw_size), .aw_burst(aw_burst), .aw_id(aw_id),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_strb(w_strb), .w_last(w_last),
    .b_valid(b_valid), .b_ready(b_ready), .b_resp(b_resp), .b_id(b_id),
    .reg_q(reg_q), .wr_mask(wr_mask), .cfg_complete(cfg_complete), .cfg_clear(cfg_clear)
`ifdef CLUSTER_CFG_ERRCNT_EN
    , .err_count(err_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- stimulus helpers (no comparisons except bounded-wait expiry) ----------------
  task automatic send_aw(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                         input logic [1:0] burst, input logic [3:0] id);
    int n = 0;
    aw_valid = 1'b1; aw_addr = addr; aw_len = len; aw_size = size; aw_burst = burst; aw_id = id;
    while (!aw_ready && n < 20) begin @(posedge clk); #1; n++; end
    if (!aw_ready) begin
      n_total++;
      $display("FAIL aw_timeout: aw_ready=%0b required 1 within 20 cycles", aw_ready);
    end
    @(posedge clk); #1;
    aw_valid = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] data, input logic [3:0] strb, input logic last);
    int n = 0;
    w_valid = 1'b1; w_data = data; w_strb = strb; w_last = last;
    while (!w_ready && n < 20) begin @(posedge clk); #1; n++; end
    if (!w_ready) begin
      n_total++;
      $display("FAIL w_timeout: w_ready=%0b required 1 within 20 cycles", w_ready);
    end
    @(posedge clk); #1;
    w_valid = 1'b0; w_last = 1'b0;
  endtask

  task automatic take_b(output logic [1:0] resp, output logic [3:0] id);
    int n = 0;
    while (!b_valid && n < 20) begin @(posedge clk); #1; n++; end
    if (!b_valid) begin
      n_total++;
      $display("FAIL b_timeout: b_valid=%0b required 1 within 20 cycles", b_valid);
    end
    resp = b_resp; id = b_id;
    b_ready = 1'b1;
    @(posedge clk); #1;
    b_ready = 1'b0;
  endtask

  // Burst whose beat i carries data d+i; bad_last inverts w_last on every beat.
  task automatic axi_write(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                           input logic [3:0] id, input logic [31:0] d, input logic [3:0] strb,
                           input logic bad_last, output logic [1:0] resp, output logic [3:0] rid);
    send_aw(addr, len, size, 2'b01, id);
    for (int i = 0; i <= int'(len); i++) send_w(d + 32'(i), strb, (i == int'(len)) ^ bad_last);
    take_b(resp, rid);
  endtask

  task automatic pulse_clear();
    cfg_clear = 1'b1;
    @(posedge clk); #1;
    cfg_clear = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    n_total++; if (reg_q !== 128'h0) $display("FAIL rst_reg_q: got %h want 0", reg_q); else n_pass++;
    n_total++; if (wr_mask !== 4'h0) $display("FAIL rst_wr_mask: got %h want 0", wr_mask); else n_pass++;
    n_total++; if (cfg_complete !== 1'b0) $display("FAIL rst_cfg_complete: got %b want 0", cfg_complete); else n_pass++;
    n_total++; if ({aw_ready, w_ready, b_valid} !== 3'b100)
      $display("FAIL rst_handshake: aw/w/b = %b want 100", {aw_ready, w_ready, b_valid}); else n_pass++;
    n_total++; if ({b_resp, b_id} !== 6'h0) $display("FAIL rst_b_fields: got %h want 0", {b_resp, b_id}); else n_pass++;
`ifdef CLUSTER_CFG_ERRCNT_EN
    n_total++; if (err_count !== 16'h0) $display("FAIL rst_err_count: got %0d want 0", err_count); else n_pass++;
`endif
  endtask

  task automatic test_single_writes();
    logic [1:0] resp; logic [3:0] id;
    for (int i = 0; i < 4; i++) begin
      send_aw(BASE + 32'(4*i), 8'd0, 3'b010, 2'b01, 4'(i + 1));
      if (i == 0) begin
        n_total++; if (w_ready !== 1'b1) $display("FAIL w_ready_latency: got %b want 1", w_ready); else n_pass++;
      end
      send_w(32'hA0 + 32'(i), 4'hF, 1'b1);
      if (i == 3) begin
        n_total++; if (wr_mask !== 4'hF) $display("FAIL mask_after_beat: got %h want f", wr_mask); else n_pass++;
        n_total++; if (cfg_complete !== 1'b0) $display("FAIL complete_early: got %b want 0", cfg_complete); else n_pass++;
        n_total++; if (b_valid !== 1'b1) $display("FAIL b_valid_latency: got %b want 1", b_valid); else n_pass++;
        @(posedge clk); #1;
        n_total++; if (cfg_complete !== 1'b1) $display("FAIL complete_rise: got %b want 1", cfg_complete); else n_pass++;
      end
      take_b(resp, id);
      n_total++; if ({resp, id} !== {2'b00, 4'(i + 1)})
        $display("FAIL single_resp[%0d]: resp/id got %b/%h want 00/%h", i, resp, id, i + 1); else n_pass++;
    end
    n_total++; if (reg_q !== {32'hA3, 32'hA2, 32'hA1, 32'hA0})
      $display("FAIL single_reg_q: got %h want a3/a2/a1/a0", reg_q); else n_pass++;
  endtask

  task automatic test_burst();
    logic [1:0] resp; logic [3:0] id;
    pulse_clear();
    n_total++; if (wr_mask !== 4'h0) $display("FAIL clear_mask: got %h want 0", wr_mask); else n_pass++;
    @(posedge clk); #1;
    n_total++; if (cfg_complete !== 1'b0) $display("FAIL clear_complete: got %b want 0", cfg_complete); else n_pass++;
    axi_write(BASE, 8'd3, 3'b010, 4'h5, 32'd1, 4'hF, 1'b0, resp, id);
    n_total++; if ({resp, id} !== 6'b00_0101) $display("FAIL burst_resp: resp/id got %b/%h want 00/5", resp, id); else n_pass++;
    n_total++; if (reg_q !== {32'd4, 32'd3, 32'd2, 32'd1}) $display("FAIL burst_reg_q: got %h want 4/3/2/1", reg_q); else n_pass++;
    n_total++; if ({wr_mask, cfg_complete} !== 5'b1111_1)
      $display("FAIL burst_complete: mask/complete got %h/%b want f/1", wr_mask, cfg_complete); else n_pass++;
  endtask

  task automatic test_out_of_range();
    logic [1:0] resp; logic [3:0] id;
    axi_write(BASE + 32'd16, 8'd0, 3'b010, 4'h6, 32'hDEAD, 4'hF, 1'b0, resp, id);
    n_total++; if ({resp, id} !== 6'b10_0110) $display("FAIL oor_resp: resp/id got %b/%h want 10/6", resp, id); else n_pass++;
    axi_write(BASE + 32'd2, 8'd0, 3'b010, 4'h7, 32'hBEEF, 4'hF, 1'b0, resp, id);
    n_total++; if ({resp, id} !== 6'b10_0111) $display("FAIL misalign_resp: resp/id got %b/%h want 10/7", resp, id); else n_pass++;
    n_total++; if (reg_q !== {32'd4, 32'd3, 32'd2, 32'd1}) $display("FAIL oor_reg_q: got %h want 4/3/2/1", reg_q); else n_pass++;
    n_total++; if (wr_mask !== 4'hF) $display("FAIL oor_mask: got %h want f", wr_mask); else n_pass++;
`ifdef CLUSTER_CFG_ERRCNT_EN
    n_total++; if (err_count !== 16'd2) $display("FAIL err_count_2: got %0d want 2", err_count); else n_pass++;
`endif
  endtask

  task automatic test_partial_and_illegal();
    logic [1:0] resp; logic [3:0] id;
    axi_write(BASE + 32'd12, 8'd1, 3'b010, 4'h8, 32'h33, 4'hF, 1'b0, resp, id);
    n_total++; if ({resp, id} !== 6'b10_1000) $display("FAIL straddle_resp: resp/id got %b/%h want 10/8", resp, id); else n_pass++;
    n_total++; if (reg_q !== {32'h33, 32'd3, 32'd2, 32'd1}) $display("FAIL straddle_reg_q: got %h want 33/3/2/1", reg_q); else n_pass++;
    axi_write(BASE, 8'd0, 3'b011, 4'h2, 32'h77, 4'hF, 1'b0, resp, id);
    n_total++; if ({resp, id} !== 6'b10_0010) $display("FAIL size_resp: resp/id got %b/%h want 10/2", resp, id); else n_pass++;
    n_total++; if (reg_q !== {32'h33, 32'd3, 32'd2, 32'd1}) $display("FAIL size_reg_q: got %h want 33/3/2/1", reg_q); else n_pass++;
    // Wrong w_last on a legal in-range beat: data lands, response is SLVERR.
    axi_write(BASE + 32'd8, 8'd0, 3'b010, 4'h3, 32'h55, 4'hF, 1'b1, resp, id);
    n_total++; if ({resp, id} !== 6'b10_0011) $display("FAIL wlast_resp: resp/id got %b/%h want 10/3", resp, id); else n_pass++;
    n_total++; if (reg_q !== {32'h33, 32'h55, 32'd2, 32'd1}) $display("FAIL wlast_reg_q: got %h want 33/55/2/1", reg_q); else n_pass++;
`ifdef CLUSTER_CFG_ERRCNT_EN
    n_total++; if (err_count !== 16'd5) $display("FAIL err_count_5: got %0d want 5", err_count); else n_pass++;
`endif
  endtask

  task automatic test_strobe_hold();
    logic [1:0] resp; logic [3:0] id;
    axi_write(BASE, 8'd0, 3'b010, 4'h1, 32'h0, 4'hF, 1'b0, resp, id);
    send_aw(BASE, 8'd0, 3'b010, 2'b01, 4'h9);
    send_w(32'hFFFF_FFFF, 4'b0101, 1'b1);
    for (int c = 0; c < 5; c++) begin
      n_total++;
      if ({b_valid, b_resp, b_id, aw_ready} !== {1'b1, 2'b00, 4'h9, 1'b0})
        $display("FAIL hold[%0d]: valid/resp/id/aw_ready got %b/%b/%h/%b want 1/00/9/0", c, b_valid, b_resp, b_id, aw_ready);
      else n_pass++;
      @(posedge clk); #1;
    end
    take_b(resp, id);
    n_total++; if ({resp, id} !== 6'b00_1001) $display("FAIL strobe_resp: resp/id got %b/%h want 00/9", resp, id); else n_pass++;
    n_total++; if (reg_q[31:0] !== 32'h00FF_00FF) $display("FAIL strobe_reg0: got %h want 00ff00ff", reg_q[31:0]); else n_pass++;
  endtask

  task automatic test_clear_collision();
    logic [1:0] resp; logic [3:0] id;
    n_total++; if (cfg_complete !== 1'b1) $display("FAIL pre_clear_complete: got %b want 1", cfg_complete); else n_pass++;
    send_aw(BASE + 32'd4, 8'd0, 3'b010, 2'b01, 4'hA);
    cfg_clear = 1'b1;
    send_w(32'h1234_5678, 4'hF, 1'b1);
    cfg_clear = 1'b0;
    n_total++; if (wr_mask !== 4'h0) $display("FAIL collide_mask: got %h want 0", wr_mask); else n_pass++;
    take_b(resp, id);
    n_total++; if ({resp, id} !== 6'b00_1010) $display("FAIL collide_resp: resp/id got %b/%h want 00/a", resp, id); else n_pass++;
    n_total++; if (reg_q[63:32] !== 32'h1234_5678) $display("FAIL collide_reg1: got %h want 12345678", reg_q[63:32]); else n_pass++;
    n_total++; if (cfg_complete !== 1'b0) $display("FAIL collide_complete: got %b want 0", cfg_complete); else n_pass++;
`ifdef CLUSTER_CFG_ERRCNT_EN
    n_total++; if (err_count !== 16'd0) $display("FAIL err_count_clear: got %0d want 0", err_count); else n_pass++;
`endif
  endtask

  task automatic test_reset_mid();
    logic [1:0] resp; logic [3:0] id;
    int seen_b = 0;
    send_aw(BASE, 8'd1, 3'b010, 2'b01, 4'hB);
    send_w(32'hCAFE, 4'hF, 1'b0);
    rst_n = 1'b0;
    #1;
    n_total++; if (reg_q !== 128'h0) $display("FAIL midrst_reg_q: got %h want 0", reg_q); else n_pass++;
    n_total++; if ({wr_mask, cfg_complete} !== 5'h0) $display("FAIL midrst_mask: got %h want 0", {wr_mask, cfg_complete}); else n_pass++;
    n_total++; if ({aw_ready, w_ready, b_valid, b_resp, b_id} !== 9'b100_00_0000)
      $display("FAIL midrst_handshake: got %b want 100000000", {aw_ready, w_ready, b_valid, b_resp, b_id}); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (b_valid) seen_b++;
    end
    n_total++; if (seen_b !== 0) $display("FAIL midrst_no_b: b_valid cycles %0d want 0", seen_b); else n_pass++;
    axi_write(BASE + 32'd8, 8'd0, 3'b010, 4'hC, 32'h99, 4'hF, 1'b0, resp, id);
    n_total++; if ({resp, id, wr_mask} !== {2'b00, 4'hC, 4'b0100})
      $display("FAIL post_rst_write: resp/id/mask got %b/%h/%h want 00/c/4", resp, id, wr_mask); else n_pass++;
  endtask

  initial begin
    rst_n = 1'b0; aw_valid = 1'b0; aw_addr = '0; aw_len = '0; aw_size = 3'b010; aw_burst = 2'b01;
    aw_id = '0; w_valid = 1'b0; w_data = '0; w_strb = '0; w_last = 1'b0; b_ready = 1'b0; cfg_clear = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_single_writes();
    test_burst();
    test_out_of_range();
    test_partial_and_illegal();
    test_strobe_hold();
    test_clear_collision();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
